// File: rtl/uart_boot_loader.sv
// UART program-image boot loader: writes 32-bit words into program memory and holds the CPU in reset until the image is complete.
// Optional trailing checksum byte is built only when BOOT_LOADER_CHECKSUM_EN is defined.
module uart_boot_loader #(
  parameter int CLKS_PER_BIT    = 868,
  parameter int PMEM_ADDR_WIDTH = 12,
  parameter int MAX_WORDS       = 1024
) (
  input  logic                       sysclk,
  input  logic                       rst,
  input  logic                       uart_rx,
  output logic                       pmem_wr_en,
  output logic [PMEM_ADDR_WIDTH-1:0] pmem_wr_addr,
  output logic [31:0]                pmem_wr_data,
  output logic [3:0]                 pmem_byte_en,
  output logic                       cpu_rst,
  output logic                       load_done,
  output logic                       load_error
);

  localparam int              CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam int              WIDX_W    = PMEM_ADDR_WIDTH - 2;
  localparam logic [WIDX_W-1:0] WIDX_ONE = WIDX_W'(1);
  localparam logic [7:0]      SYNC_BYTE = 8'hA5;
  localparam logic [15:0]     MAX_N     = 16'(MAX_WORDS);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  typedef enum logic [2:0] {
    WAIT_SYNC,
    LEN_LO,
    LEN_HI,
    DATA,
`ifdef BOOT_LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE,
    ERROR
  } state_t;

  logic rx_meta_q, rx_sync_q, rx_prev_q;

  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_ferr_q, rx_ferr_d;

  state_t                     state_q, state_d;
  logic [7:0]                 len_lo_q, len_lo_d;
  logic [15:0]                count_q, count_d;
  logic [WIDX_W-1:0]          word_idx_q, word_idx_d;
  logic [1:0]                 byte_idx_q, byte_idx_d;
  logic [23:0]                word_sr_q, word_sr_d;
  logic                       wr_en_q, wr_en_d;
  logic [PMEM_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]                wr_data_q, wr_data_d;
  logic                       cpu_rst_q, cpu_rst_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [7:0]                 sum_q, sum_d;
`endif

  logic [15:0] len_full;
  logic        last_word;

  assign len_full  = {rx_shift_q, len_lo_q};
  assign last_word = (16'(word_idx_q) == (count_q - 16'd1));

  // Bits are sampled at their centres: half a bit after the start edge, then every full bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_sync_q && rx_prev_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_valid_d = rx_sync_q;
          rx_ferr_d  = !rx_sync_q;
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    word_sr_d  = word_sr_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    cpu_rst_d  = (state_q == DONE) ? 1'b0 : cpu_rst_q;
    done_d     = done_q;
    err_d      = err_q;
`ifdef BOOT_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    if (rx_ferr_q && state_q != DONE) begin
      state_d = ERROR;
      err_d   = 1'b1;
    end else if (rx_valid_q) begin
      case (state_q)
        WAIT_SYNC, ERROR: begin
          if (rx_shift_q == SYNC_BYTE) begin
            state_d    = LEN_LO;
            err_d      = 1'b0;
            word_idx_d = '0;
            byte_idx_d = '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
            sum_d      = '0;
`endif
          end
        end
        LEN_LO: begin
          len_lo_d = rx_shift_q;
          state_d  = LEN_HI;
        end
        LEN_HI: begin
          count_d    = len_full;
          word_idx_d = '0;
          byte_idx_d = '0;
          if (len_full > MAX_N) begin
            state_d = ERROR;
            err_d   = 1'b1;
          end else if (len_full == 16'd0) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = DONE;
            done_d  = 1'b1;
`endif
          end else begin
            state_d = DATA;
          end
        end
        DATA: begin
          word_sr_d  = {rx_shift_q, word_sr_q[23:8]};
          byte_idx_d = byte_idx_q + 2'd1;
`ifdef BOOT_LOADER_CHECKSUM_EN
          sum_d      = sum_q + rx_shift_q;
`endif
          // The fourth byte completes the word; it is written straight from the receive register.
          if (byte_idx_q == 2'd3) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = {word_idx_q, 2'b00};
            wr_data_d  = {rx_shift_q, word_sr_q};
            word_idx_d = word_idx_q + WIDX_ONE;
            if (last_word) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
              state_d = CHECK;
`else
              state_d = DONE;
              done_d  = 1'b1;
`endif
            end
          end
        end
`ifdef BOOT_LOADER_CHECKSUM_EN
        CHECK: begin
          if (rx_shift_q == sum_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ERROR;
            err_d   = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      state_q    <= WAIT_SYNC;
      len_lo_q   <= '0;
      count_q    <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      word_sr_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      rx_meta_q  <= uart_rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      word_sr_q  <= word_sr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign pmem_wr_en   = wr_en_q;
  assign pmem_wr_addr = wr_addr_q;
  assign pmem_wr_data = wr_data_q;
  assign pmem_byte_en = {4{wr_en_q}};
  assign cpu_rst      = cpu_rst_q;
  assign load_done    = done_q;
  assign load_error   = err_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: stimulus queues expected memory writes, a monitor pops and checks them.
module tb_uart_boot_loader;

  localparam int CPB = 4;
  localparam int AW  = 12;

  logic          sysclk = 1'b0;
  logic          rst = 1'b1;
  logic          uart_rx = 1'b1;
  logic          pmem_wr_en;
  logic [AW-1:0] pmem_wr_addr;
  logic [31:0]   pmem_wr_data;
  logic [3:0]    pmem_byte_en;
  logic          cpu_rst;
  logic          load_done;
  logic          load_error;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t        expQ[$];
  wr_t        monExp;
  logic [7:0] txQ[$];
  int         nChecks = 0;
  int         nPass = 0;
  int         idleViol = 0;

  always #5 sysclk = ~sysclk;

  uart_boot_loader #(
    .CLKS_PER_BIT(CPB),
    .PMEM_ADDR_WIDTH(AW),
    .MAX_WORDS(1024)
  ) dut (
    .sysclk(sysclk),
    .rst(rst),
    .uart_rx(uart_rx),
    .pmem_wr_en(pmem_wr_en),
    .pmem_wr_addr(pmem_wr_addr),
    .pmem_wr_data(pmem_wr_data),
    .pmem_byte_en(pmem_byte_en),
    .cpu_rst(cpu_rst),
    .load_done(load_done),
    .load_error(load_error)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual === expected) nPass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  // Monitor: every write strobe must match the oldest queued expectation.
  always @(negedge sysclk) begin
    if (pmem_wr_en === 1'b1) begin
      checkOutput("write_expected", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) begin
        monExp = expQ.pop_front();
        checkOutput("wr_addr", 32'(pmem_wr_addr), 32'(monExp.addr));
        checkOutput("wr_data", pmem_wr_data, monExp.data);
        checkOutput("wr_byte_en", 32'(pmem_byte_en), 32'hF);
      end
    end else if (pmem_byte_en !== 4'h0) begin
      idleViol++;
    end
  end

  task automatic expectWrite(input logic [AW-1:0] addr, input logic [31:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge sysclk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge sysclk);
    end
    uart_rx = stopBit;
    repeat (CPB) @(negedge sysclk);
    uart_rx = 1'b1;
  endtask

  task automatic flushTx();
    while (txQ.size() != 0) applyStimulus(txQ.pop_front(), 1'b1);
  endtask

  task automatic doReset();
    @(negedge sysclk);
    uart_rx = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge sysclk);
    rst = 1'b0;
    repeat (4) @(negedge sysclk);
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    while (load_done !== 1'b1 && n < 200) begin
      @(negedge sysclk);
      n++;
    end
    checkOutput({name, "_done"}, 32'(load_done), 32'd1);
    checkOutput({name, "_cpu_rst_held"}, 32'(cpu_rst), 32'd1);
    @(negedge sysclk);
    checkOutput({name, "_cpu_rst_released"}, 32'(cpu_rst), 32'd0);
    checkOutput({name, "_no_error"}, 32'(load_error), 32'd0);
  endtask

  task automatic waitError(input string name);
    int n = 0;
    while (load_error !== 1'b1 && n < 200) begin
      @(negedge sysclk);
      n++;
    end
    checkOutput({name, "_error"}, 32'(load_error), 32'd1);
    repeat (5) @(negedge sysclk);
    checkOutput({name, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
    checkOutput({name, "_not_done"}, 32'(load_done), 32'd0);
  endtask

  task automatic endScenario(input string name);
    repeat (10) @(negedge sysclk);
    checkOutput({name, "_writes_pending"}, 32'(expQ.size()), 32'd0);
    checkOutput({name, "_idle_byte_en"}, 32'(idleViol), 32'd0);
    expQ.delete();
    idleViol = 0;
  endtask

  initial begin
    int bad;
    doReset();

    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge sysclk);
      if (cpu_rst !== 1'b1 || load_done !== 1'b0 || load_error !== 1'b0 || pmem_wr_en !== 1'b0) bad++;
    end
    checkOutput("reset_idle_bad_cycles", 32'(bad), 32'd0);
    checkOutput("reset_wr_addr", 32'(pmem_wr_addr), 32'd0);
    checkOutput("reset_wr_data", pmem_wr_data, 32'd0);
    endScenario("idle");

    // Two-word image, then a stray byte that DONE must ignore.
    expectWrite(12'h000, 32'h0000_0013);
    expectWrite(12'h004, 32'h0010_0093);
    txQ = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
`ifdef BOOT_LOADER_CHECKSUM_EN
    txQ.push_back(8'hB6);
`endif
    flushTx();
    waitDone("two_word");
    applyStimulus(8'hA5, 1'b1);
    repeat (5) @(negedge sysclk);
    checkOutput("two_word_extra_done", 32'(load_done), 32'd1);
    checkOutput("two_word_extra_err", 32'(load_error), 32'd0);
    endScenario("two_word");

    doReset();
    expectWrite(12'h000, 32'hDEAD_BEEF);
    txQ = '{8'h3C, 8'h7E, 8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef BOOT_LOADER_CHECKSUM_EN
    txQ.push_back(8'h38);
`endif
    flushTx();
    waitDone("sync_drop");
    endScenario("sync_drop");

`ifdef BOOT_LOADER_CHECKSUM_EN
    doReset();
    expectWrite(12'h000, 32'h1122_3344);
    txQ = '{8'hA5, 8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h00};
    flushTx();
    waitError("bad_sum");
    expectWrite(12'h000, 32'hCAFE_F00D);
    txQ = '{8'hA5, 8'h01, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'hC5};
    flushTx();
    waitDone("retry");
    endScenario("bad_sum");
`endif

    doReset();
    txQ = '{8'hA5, 8'h00, 8'h00};
`ifdef BOOT_LOADER_CHECKSUM_EN
    txQ.push_back(8'h00);
`endif
    flushTx();
    waitDone("zero_len");
    endScenario("zero_len");

    doReset();
    txQ = '{8'hA5, 8'h01, 8'h04};
    flushTx();
    waitError("too_long");
    endScenario("too_long");

    doReset();
    applyStimulus(8'hA5, 1'b0);
    waitError("framing");
    endScenario("framing");

    // A glitch must not start a frame; if it did, the receiver would miss the image that follows.
    doReset();
    uart_rx = 1'b0;
    repeat (2) @(negedge sysclk);
    uart_rx = 1'b1;
    repeat (4) @(negedge sysclk);
    expectWrite(12'h000, 32'h0000_0013);
    txQ = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
`ifdef BOOT_LOADER_CHECKSUM_EN
    txQ.push_back(8'h13);
`endif
    flushTx();
    waitDone("glitch");
    endScenario("glitch");

    doReset();
    expectWrite(12'h000, 32'h0102_0304);
    expectWrite(12'h004, 32'h0506_0708);
    txQ = '{8'hA5, 8'h04, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01, 8'h08, 8'h07, 8'h06, 8'h05, 8'h0C, 8'h0B};
    flushTx();
    repeat (10) @(negedge sysclk);
    checkOutput("midload_addr_before", 32'(pmem_wr_addr), 32'h004);
    checkOutput("midload_queue_before", 32'(expQ.size()), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("midload_rst_wr_en", 32'(pmem_wr_en), 32'd0);
    checkOutput("midload_rst_addr", 32'(pmem_wr_addr), 32'd0);
    checkOutput("midload_rst_data", pmem_wr_data, 32'd0);
    checkOutput("midload_rst_byte_en", 32'(pmem_byte_en), 32'd0);
    checkOutput("midload_rst_cpu_rst", 32'(cpu_rst), 32'd1);
    checkOutput("midload_rst_done", 32'(load_done), 32'd0);
    checkOutput("midload_rst_error", 32'(load_error), 32'd0);
    repeat (2) @(negedge sysclk);
    rst = 1'b0;
    repeat (4) @(negedge sysclk);
    expectWrite(12'h000, 32'h55AA_55AA);
    txQ = '{8'hA5, 8'h01, 8'h00, 8'hAA, 8'h55, 8'hAA, 8'h55};
`ifdef BOOT_LOADER_CHECKSUM_EN
    txQ.push_back(8'hFE);
`endif
    flushTx();
    waitDone("after_rst");
    endScenario("after_rst");

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Upstream feeder for the CPU's program memory.
- Receives a program image over a UART serial line and writes 32-bit instruction words into the program-memory BRAM write port.
- Holds the CPU core in reset until a complete, valid image has been loaded, then releases it.

Parameters:
- CLKS_PER_BIT, 868, sysclk cycles per UART bit (100 MHz / 115200 baud).
- PMEM_ADDR_WIDTH, 12, width of the program-memory byte address.
- MAX_WORDS, 1024, largest accepted word count; must be <= 2^PMEM_ADDR_WIDTH / 4.

Ports:
- sysclk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- uart_rx  input  1  serial input, idle high, 8N1, LSB first.
- pmem_wr_en  output  1  one-cycle write strobe to program memory.
- pmem_wr_addr  output  PMEM_ADDR_WIDTH  byte address of the word being written; always word aligned.
- pmem_wr_data  output  32  instruction word being written.
- pmem_byte_en  output  4  byte enables; 4'b1111 whenever pmem_wr_en is high, 4'b0000 otherwise.
- cpu_rst  output  1  reset to the CPU core; high until the load completes.
- load_done  output  1  image loaded and accepted.
- load_error  output  1  protocol, framing or checksum error.

Behaviour:
- Clock and reset: one clock, sysclk. Reset is asynchronous and active-high.
- Reset values: pmem_wr_en=0, pmem_wr_addr=0, pmem_wr_data=0, pmem_byte_en=0, cpu_rst=1, load_done=0, load_error=0. FSM goes to WAIT_SYNC.
- Reset mid-load aborts the load; memory already written is left as is.
- RX front end:
  - uart_rx passes through a 2-flop synchroniser; synchroniser reset value is 1.
  - A falling edge while idle starts a frame. The start bit is re-sampled at CLKS_PER_BIT/2; if it reads high, it is a glitch and is ignored.
  - Data bits are sampled at bit centres, spaced CLKS_PER_BIT apart.
  - Stop bit sampled low = framing error: byte discarded, FSM goes to ERROR.
  - A valid byte raises an internal rx_valid for one cycle.
- Protocol, in order:
  - sync byte 0xA5;
  - word count N, 16-bit little-endian, in two bytes;
  - N words, 4 bytes each, little-endian;
  - 1-byte checksum (only when the checksum feature is compiled in).
- FSM states: WAIT_SYNC, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR.
- WAIT_SYNC:
  - 0xA5 -> LEN_LO.
  - Any other byte is silently dropped; no error.
- LEN_LO: capture the low byte of N -> LEN_HI.
- LEN_HI: capture the high byte of N.
  - N > MAX_WORDS -> ERROR.
  - N = 0 -> CHECK (feature on) or DONE (feature off).
  - Otherwise -> DATA, with byte index 0 and word address 0.
- DATA:
  - Bytes are assembled into a shift register.
  - The cycle after the 4th byte of a word: pmem_wr_en=1 for exactly one cycle, with pmem_wr_addr = 4*word_index and pmem_wr_data = the assembled word (first byte received in bits [7:0]).
  - After writing word N-1 -> CHECK or DONE.
- Write address: increments by 4 after each write. It never wraps, because N is bounded by MAX_WORDS.
- Running sum: an 8-bit sum, mod 256, of all data bytes only. Header bytes are excluded.
- DONE:
  - load_done=1.
  - cpu_rst falls one cycle after DONE is entered; the final write is therefore complete before the CPU leaves reset.
  - Further UART bytes are ignored until rst.
- ERROR:
  - load_error=1 and cpu_rst stays 1.
  - A received 0xA5 clears load_error, resets the counters and the sum, and goes to LEN_LO (retry without a global reset).
  - Other bytes are ignored.
- No back-pressure: program memory accepts a write every cycle. The minimum byte spacing (10*CLKS_PER_BIT) far exceeds the 1-cycle write latency.

Optional Feature:
- Macro: BOOT_LOADER_CHECKSUM_EN.
- Defined:
  - After the last word the FSM enters CHECK and waits for one byte.
  - Byte equal to the running sum -> DONE.
  - Byte different -> ERROR. Words already written stay in memory, but the CPU remains in reset.
- Undefined:
  - The CHECK state and the sum logic are not built.
  - The FSM goes to DONE immediately after the last write, or directly from LEN_HI when N=0.
  - No checksum byte is expected; any extra byte is ignored in DONE.

Test Plan (CLKS_PER_BIT=4):
- Reset, line idle: cpu_rst=1, load_done=0, load_error=0, pmem_wr_en=0 for 1000 cycles.
- Send A5 02 00 13 00 00 00 93 00 10 00 + checksum B6:
  - exactly two writes: addr 0x000 data 0x00000013, then addr 0x004 data 0x00100093, both with byte_en 4'hF;
  - then load_done=1, and cpu_rst falls one cycle later.
- Send 3C 7E, then a valid 1-word image: 3C and 7E are ignored, one write at addr 0, load_done=1.
- Send A5 01 00 + 4 data bytes + wrong checksum: one write occurs, then load_error=1 and cpu_rst=1. A following valid image clears load_error and ends in load_done=1.
- Send A5 01 04 (N=1025 > MAX_WORDS): load_error=1, no writes.
- Send a frame with its stop bit held low: load_error=1, byte discarded. A 2-cycle low glitch on an idle line produces no byte.
- Assert rst midway through word 3 of a 4-word load: all outputs return to reset values immediately, and the next load starts at addr 0.
